// File: rtl/cv32e40s_alert_escalate.sv
// Security alert aggregator: registers major/minor integrity alerts, escalates bursts of
// minor events through a leaky-bucket counter and latches the first major cause for debug.
module cv32e40s_alert_escalate #(
  parameter int unsigned MINOR_THRESHOLD = 4,
  parameter int unsigned LEAK_CYCLES     = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pc_err_i,
  input  logic       rf_ecc_err_i,
  input  logic       bus_int_err_i,
  input  logic       csr_shadow_err_i,
  input  logic [2:0] lfsr_lockup_i,
  input  logic       exception_i,
  input  logic       cause_clr_i,
  output logic       alert_major_o,
  output logic       alert_minor_o,
  output logic       major_sticky_o,
  output logic [4:0] first_cause_o,
  output logic [3:0] minor_cnt_o
);

  localparam logic [3:0]  EscCnt   = 4'(MINOR_THRESHOLD - 1);
  localparam logic [15:0] LeakLast = 16'(LEAK_CYCLES - 1);

  logic        major_any;
  logic        minor_any;
  logic        esc;
  logic        leak_expire;
  logic        alert_major_d;
  logic        alert_major_q;
  logic        alert_minor_q;
  logic        sticky_d;
  logic        sticky_q;
  logic [4:0]  cause_src;
  logic [4:0]  cause_d;
  logic [4:0]  cause_q;
  logic [3:0]  cnt_d;
  logic [3:0]  cnt_q;
  logic [15:0] timer_d;
  logic [15:0] timer_q;

  // Source decode
  always_comb begin
    major_any     = pc_err_i | rf_ecc_err_i | bus_int_err_i | csr_shadow_err_i;
    minor_any     = (|lfsr_lockup_i) | exception_i;
    esc           = minor_any && (cnt_q == EscCnt);
    leak_expire   = (timer_q == LeakLast);
    alert_major_d = major_any | esc;
    cause_src     = {esc, csr_shadow_err_i, bus_int_err_i, rf_ecc_err_i, pc_err_i};
  end

  // Leaky bucket: a minor event always wins over a coincident leak expiry.
  always_comb begin
    cnt_d   = cnt_q;
    timer_d = timer_q;
    if (minor_any) begin
      timer_d = '0;
      cnt_d   = esc ? 4'd0 : cnt_q + 4'd1;
    end else if (leak_expire) begin
      timer_d = '0;
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  // First-cause capture; a new major event in the clear cycle reloads rather than clears.
  always_comb begin
    cause_d  = cause_q;
    sticky_d = sticky_q | alert_major_d;
    if (alert_major_d && ((cause_q == 5'd0) || cause_clr_i)) begin
      cause_d = cause_src;
    end else if (cause_clr_i) begin
      cause_d = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_major_q <= 1'b0;
      alert_minor_q <= 1'b0;
      sticky_q      <= 1'b0;
      cause_q       <= 5'd0;
      cnt_q         <= 4'd0;
      timer_q       <= 16'd0;
    end else begin
      alert_major_q <= alert_major_d;
      alert_minor_q <= minor_any;
      sticky_q      <= sticky_d;
      cause_q       <= cause_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    alert_major_o  = alert_major_q;
    alert_minor_o  = alert_minor_q;
    major_sticky_o = sticky_q;
    first_cause_o  = cause_q;
    minor_cnt_o    = cnt_q;
  end

endmodule

// File: tb/tb_cv32e40s_alert_escalate.sv
// Scoreboard bench for cv32e40s_alert_escalate (MINOR_THRESHOLD=4, LEAK_CYCLES=8).
module tb_cv32e40s_alert_escalate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pc_err_i = 1'b0;
  logic       rf_ecc_err_i = 1'b0;
  logic       bus_int_err_i = 1'b0;
  logic       csr_shadow_err_i = 1'b0;
  logic [2:0] lfsr_lockup_i = 3'b000;
  logic       exception_i = 1'b0;
  logic       cause_clr_i = 1'b0;
  logic       alert_major_o;
  logic       alert_minor_o;
  logic       major_sticky_o;
  logic [4:0] first_cause_o;
  logic [3:0] minor_cnt_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         chk;
    logic       maj;
    logic       mnr;
    logic       stk;
    logic [4:0] cause;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  cv32e40s_alert_escalate #(
    .MINOR_THRESHOLD(4),
    .LEAK_CYCLES    (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_err_i        (pc_err_i),
    .rf_ecc_err_i    (rf_ecc_err_i),
    .bus_int_err_i   (bus_int_err_i),
    .csr_shadow_err_i(csr_shadow_err_i),
    .lfsr_lockup_i   (lfsr_lockup_i),
    .exception_i     (exception_i),
    .cause_clr_i     (cause_clr_i),
    .alert_major_o   (alert_major_o),
    .alert_minor_o   (alert_minor_o),
    .major_sticky_o  (major_sticky_o),
    .first_cause_o   (first_cause_o),
    .minor_cnt_o     (minor_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(bit chk, logic maj, logic mnr, logic stk, logic [4:0] cause,
                              logic [3:0] cnt, string name);
    exp_t e;
    e.chk = chk; e.maj = maj; e.mnr = mnr; e.stk = stk;
    e.cause = cause; e.cnt = cnt; e.name = name;
    return e;
  endfunction

  // Fields ordered {major, minor, sticky, cause[4:0], cnt[3:0]}
  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got maj/min/stk/cause/cnt=%b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
               name, act[11], act[10], act[9], act[8:4], act[3:0],
               req[11], req[10], req[9], req[8:4], req[3:0]);
    end
  endtask

  function automatic logic [11:0] outs();
    return {alert_major_o, alert_minor_o, major_sticky_o, first_cause_o, minor_cnt_o};
  endfunction

  // One cycle of stimulus; the expectation applies to outputs after the next rising edge.
  task automatic step(input logic [3:0] maj_src, input logic [2:0] lfsr, input logic exc,
                      input logic clr, input exp_t e);
    @(negedge clk);
    {csr_shadow_err_i, bus_int_err_i, rf_ecc_err_i, pc_err_i} = maj_src;
    lfsr_lockup_i = lfsr;
    exception_i   = exc;
    cause_clr_i   = clr;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a registered output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) check(e.name, outs(), {e.maj, e.mnr, e.stk, e.cause, e.cnt});
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #3 check("reset_values", outs(), 12'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle PC error, then a later RF error must not overwrite the cause
    repeat (9) step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 0, 5'b00000, 0, "idle"));
    step(4'b0001, 3'b000, 1'b0, 1'b0, mk(1, 1, 0, 1, 5'b00001, 0, "pc_alert"));
    step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b00001, 0, "pc_drop"));
    step(4'b0010, 3'b000, 1'b0, 1'b0, mk(1, 1, 0, 1, 5'b00001, 0, "rf_cause_held"));
    step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b00001, 0, "rf_drop"));

    // Clear coincident with bus error: set wins; then a plain clear
    step(4'b0100, 3'b000, 1'b0, 1'b1, mk(1, 1, 0, 1, 5'b00100, 0, "clr_with_bus"));
    step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b00100, 0, "bus_cause_held"));
    step(4'b0000, 3'b000, 1'b0, 1'b1, mk(1, 0, 0, 1, 5'b00000, 0, "clr_alone"));

    // Four exception pulses spaced 5 cycles apart escalate on the fourth
    for (int i = 1; i <= 3; i++) begin
      step(4'b0000, 3'b000, 1'b1, 1'b0, mk(1, 0, 1, 1, 5'b00000, 4'(i), "exc_count"));
      repeat (4) step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b00000, 4'(i), "exc_gap"));
    end
    step(4'b0000, 3'b000, 1'b1, 1'b0, mk(1, 1, 1, 1, 5'b10000, 0, "escalate"));
    step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b10000, 0, "escalate_drop"));

    // Three minor events then leak down: one decrement per 8 quiet cycles, floor at 0
    step(4'b0000, 3'b001, 1'b0, 1'b0, mk(1, 0, 1, 1, 5'b10000, 1, "leak_fill1"));
    step(4'b0000, 3'b000, 1'b1, 1'b0, mk(1, 0, 1, 1, 5'b10000, 2, "leak_fill2"));
    step(4'b0000, 3'b010, 1'b0, 1'b0, mk(1, 0, 1, 1, 5'b10000, 3, "leak_fill3"));
    for (int k = 1; k <= 34; k++) begin
      step(4'b0000, 3'b000, 1'b0, 1'b0,
           mk(1, 0, 0, 1, 5'b10000, (k < 24) ? 4'(3 - k / 8) : 4'd0, "leak_down"));
    end

    // Minor event exactly at leak expiry with count 2: event wins, timer restarts
    step(4'b0000, 3'b001, 1'b0, 1'b0, mk(1, 0, 1, 1, 5'b10000, 1, "race_fill1"));
    step(4'b0000, 3'b000, 1'b1, 1'b0, mk(1, 0, 1, 1, 5'b10000, 2, "race_fill2"));
    repeat (7) step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b10000, 2, "race_wait"));
    step(4'b0000, 3'b000, 1'b1, 1'b0, mk(1, 0, 1, 1, 5'b10000, 3, "race_event_wins"));
    repeat (7) step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b10000, 3, "race_restart"));
    step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 1, 5'b10000, 2, "race_leak"));

    // All LFSRs locked for 3 cycles (count starts at 2), then reset mid-burst
    step(4'b0000, 3'b111, 1'b0, 1'b0, mk(1, 0, 1, 1, 5'b10000, 3, "lfsr_burst1"));
    step(4'b0000, 3'b111, 1'b0, 1'b0, mk(1, 1, 1, 1, 5'b10000, 0, "lfsr_burst_esc"));
    step(4'b0000, 3'b111, 1'b0, 1'b0, mk(1, 0, 1, 1, 5'b10000, 1, "lfsr_burst3"));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("reset_async", outs(), 12'd0);
    lfsr_lockup_i = 3'b000;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", outs(), 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 3'b111, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b00000, 1, "restart1"));
    step(4'b0000, 3'b000, 1'b1, 1'b0, mk(1, 0, 1, 0, 5'b00000, 2, "restart2"));
    step(4'b0000, 3'b000, 1'b0, 1'b0, mk(1, 0, 0, 0, 5'b00000, 2, "restart_idle"));

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
